// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D memory arbiter, one fixed-latency transaction in flight
// Outputs other than captured read data and grant counters are decoded from the FSM state.
module mem_arbiter #(
   parameter int LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_data,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_data,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [15:0] i_grant_cnt,
   output logic [15:0] d_grant_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

   logic [1:0]  state_q, state_d;
   logic        last_d_q, last_d_d;   // 1 when the data side won the previous grant
   logic        sel_d_q, sel_d_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [3:0]  lat_q, lat_d;
   logic [15:0] i_data_q, i_data_d;
   logic [15:0] d_data_q, d_data_d;
   logic [15:0] i_cnt_q, i_cnt_d;
   logic [15:0] d_cnt_q, d_cnt_d;
   logic        win_d;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      sel_d_d  = sel_d_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lat_d    = lat_q;
      i_data_d = i_data_q;
      d_data_d = d_data_q;
      i_cnt_d  = i_cnt_q;
      d_cnt_d  = d_cnt_q;
      win_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               win_d    = d_req && (!i_req || !last_d_q);
               sel_d_d  = win_d;
               last_d_d = win_d;
               wr_d     = win_d ? d_wr : 1'b0;
               addr_d   = win_d ? d_addr : i_addr;
               wdata_d  = win_d ? d_wdata : 16'h0000;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Last wait cycle is exactly LAT cycles after ISSUE: read data is on mem_rdata now.
            if (lat_q == 4'd0) begin
               if (!wr_q) begin
                  if (sel_d_q) d_data_d = mem_rdata;
                  else         i_data_d = mem_rdata;
               end
               state_d = ST_DONE;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         default: begin
            if (sel_d_q) begin
               if (d_cnt_q != 16'hFFFF) d_cnt_d = d_cnt_q + 16'd1;
            end else begin
               if (i_cnt_q != 16'hFFFF) i_cnt_d = i_cnt_q + 16'd1;
            end
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         last_d_q <= 1'b0;
         sel_d_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 16'h0000;
         lat_q    <= 4'd0;
         i_data_q <= 16'h0000;
         d_data_q <= 16'h0000;
         i_cnt_q  <= 16'h0000;
         d_cnt_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         sel_d_q  <= sel_d_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lat_q    <= lat_d;
         i_data_q <= i_data_d;
         d_data_q <= d_data_d;
         i_cnt_q  <= i_cnt_d;
         d_cnt_q  <= d_cnt_d;
      end
   end

   assign mem_en      = (state_q == ST_ISSUE);
   assign mem_wr      = mem_en && wr_q;
   assign mem_addr    = mem_en ? addr_q : 16'h0000;
   assign mem_wdata   = mem_en ? wdata_q : 16'h0000;
   assign i_done      = (state_q == ST_DONE) && !sel_d_q;
   assign d_done      = (state_q == ST_DONE) && sel_d_q;
   assign i_data      = i_data_q;
   assign d_data      = d_data_q;
   assign i_grant_cnt = i_cnt_q;
   assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - bench for mem_arbiter: vector table, corner sequences, random vs model
// A second instance with LAT=1 covers done spacing and counter saturation.
module tb_mem_arbiter;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_done, d_done, mem_en, mem_wr;
   logic [15:0] i_data, d_data, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt;

   logic        s_rst = 1'b1;
   logic        s_i_req, s_d_req, s_d_wr;
   logic [15:0] s_i_addr, s_d_addr, s_d_wdata, s_mem_rdata;
   logic        s_i_done, s_d_done, s_mem_en, s_mem_wr;
   logic [15:0] s_i_data, s_d_data, s_mem_addr, s_mem_wdata, s_i_cnt, s_d_cnt;

   always #5 clk = ~clk;

   mem_arbiter #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_data(i_data),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_data(d_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   mem_arbiter #(.LAT(1)) dut_sat (
      .clk(clk), .rst(s_rst),
      .i_req(s_i_req), .i_addr(s_i_addr), .i_done(s_i_done), .i_data(s_i_data),
      .d_req(s_d_req), .d_wr(s_d_wr), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
      .d_done(s_d_done), .d_data(s_d_data),
      .mem_en(s_mem_en), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .i_grant_cnt(s_i_cnt), .d_grant_cnt(s_d_cnt)
   );

   typedef struct {
      logic        side_d;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic [15:0] exp_data;
   } vec_t;

   vec_t        vecs[5];
   int          total = 0;
   int          bad = 0;

   int          en_cnt, en_cyc, done_cnt, done_cyc;
   logic        wr_seen, side_seen;
   logic [15:0] a_seen, w_seen, data_seen;
   int          ido[$], ddo[$], iss[$];
   logic [15:0] iss_addr[$];
   logic        any_done;

   int          ph, g;
   bit          busy, m_side, m_wr, m_last;
   logic [15:0] m_addr, m_wdata, m_rd, m_idata, m_ddata;
   int          m_icnt, m_dcnt;
   bit          i_act, d_act, i_drop, d_drop;
   logic [15:0] r_iaddr, r_daddr, r_dwdata;
   bit          r_dwr;

   logic [15:0] s_rd[32];
   int          s_done[$];
   int          s_exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
      d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
   endtask

   // Leaves the bench at the start of cycle 0 with rst low.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      mem_rdata = 16'hA5A5;
      tick();
      @(negedge clk);
      check("rst_ctl", {mem_en, mem_wr, i_done, d_done}, 0);
      check("rst_bus", {mem_addr, mem_wdata}, 0);
      check("rst_data", {i_data, d_data}, 0);
      check("rst_cnt", {i_grant_cnt, d_grant_cnt}, 0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 16'h1000, 16'h1234, 16'hDEAD, 16'h0000};
      vecs[2] = '{1'b0, 1'b1, 16'h7F7F, 16'h1111, 16'h8001, 16'h8001};
      vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h5555, 16'hFFFF, 16'hFFFF};
      vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'hAAAA, 16'h0001, 16'h0001};
      s_i_req = 1'b0; s_i_addr = 16'h0; s_d_req = 1'b0; s_d_wr = 1'b0;
      s_d_addr = 16'h0; s_d_wdata = 16'h0; s_mem_rdata = 16'h0;

      // Single transactions from the table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         en_cnt = 0; en_cyc = -1; done_cnt = 0; done_cyc = -1;
         wr_seen = 1'b0; side_seen = 1'b0; a_seen = 16'h0; w_seen = 16'h0; data_seen = 16'h0;
         for (int c = 0; c < LAT + 6; c++) begin
            if (vecs[v].side_d) begin
               d_req = (done_cyc < 0); d_wr = vecs[v].wr;
               d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            end else begin
               i_req = (done_cyc < 0); i_addr = vecs[v].addr;
               d_wr = vecs[v].wr; d_wdata = vecs[v].wdata;
            end
            mem_rdata = (c == LAT + 1) ? vecs[v].rdata : 16'($urandom);
            @(negedge clk);
            if (mem_en) begin
               en_cnt++; en_cyc = c; a_seen = mem_addr; w_seen = mem_wdata; wr_seen = mem_wr;
            end
            if (i_done || d_done) begin
               done_cnt++; done_cyc = c; side_seen = d_done;
               data_seen = d_done ? d_data : i_data;
            end
            tick();
         end
         check($sformatf("v%0d_en_cnt", v), en_cnt, 1);
         check($sformatf("v%0d_en_cyc", v), en_cyc, 1);
         check($sformatf("v%0d_addr", v), a_seen, vecs[v].addr);
         check($sformatf("v%0d_wr", v), wr_seen, vecs[v].side_d && vecs[v].wr);
         check($sformatf("v%0d_wdata", v), w_seen, vecs[v].side_d ? vecs[v].wdata : 16'h0);
         check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
         check($sformatf("v%0d_done_cyc", v), done_cyc, LAT + 2);
         check($sformatf("v%0d_side", v), side_seen, vecs[v].side_d);
         check($sformatf("v%0d_data", v), data_seen, vecs[v].exp_data);
         check($sformatf("v%0d_icnt", v), i_grant_cnt, !vecs[v].side_d);
         check($sformatf("v%0d_dcnt", v), d_grant_cnt, vecs[v].side_d);
      end

      // Tie after reset: D, then I, then D again
      do_reset();
      ido.delete(); ddo.delete(); iss.delete(); iss_addr.delete();
      i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200; d_wr = 1'b0;
      for (int c = 0; c < 22; c++) begin
         mem_rdata = 16'($urandom);
         @(negedge clk);
         check("tie_excl", i_done & d_done, 0);
         if (i_done) ido.push_back(c);
         if (d_done) ddo.push_back(c);
         if (mem_en) begin iss.push_back(c); iss_addr.push_back(mem_addr); end
         tick();
      end
      check("tie_d_n", ddo.size(), 2);
      check("tie_i_n", ido.size(), 1);
      check("tie_iss_n", iss.size(), 3);
      if (ddo.size() == 2 && ido.size() == 1 && iss.size() == 3) begin
         check("tie_d0", ddo[0], 6);
         check("tie_i0", ido[0], 13);
         check("tie_d1", ddo[1], 20);
         check("tie_iss1", iss[1], 8);
         check("tie_a0", iss_addr[0], 16'h0200);
         check("tie_a1", iss_addr[1], 16'h0100);
         check("tie_a2", iss_addr[2], 16'h0200);
      end

      // Reset in the middle of an I transaction
      do_reset();
      i_req = 1'b1; i_addr = 16'h0040;
      any_done = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (c == 3) begin rst = 1'b1; i_req = 1'b0; end
         if (c == 4) rst = 1'b0;
         mem_rdata = 16'($urandom);
         @(negedge clk);
         if (c == 1) check("mrst_en1", mem_en, 1);
         if (c >= 4) begin
            check("mrst_ctl", {mem_en, mem_wr, i_done, d_done}, 0);
            check("mrst_bus", {mem_addr, mem_wdata}, 0);
            check("mrst_data", {i_data, d_data}, 0);
         end
         any_done = any_done | i_done;
         tick();
      end
      check("mrst_no_done", any_done, 0);
      check("mrst_icnt", i_grant_cnt, 0);

      // Request dropped mid-transaction still completes
      do_reset();
      ido.delete(); iss.delete();
      i_req = 1'b1; i_addr = 16'h0ABC;
      for (int c = 0; c < 16; c++) begin
         if (c == 2) i_req = 1'b0;
         if (c == 12) begin i_req = 1'b1; i_addr = 16'h0DEF; end
         mem_rdata = (c == LAT + 1) ? 16'h4242 : 16'($urandom);
         @(negedge clk);
         if (i_done) begin ido.push_back(c); check("drop_data", i_data, 16'h4242); end
         if (mem_en) iss.push_back(c);
         tick();
      end
      check("drop_done_n", ido.size(), 1);
      check("drop_iss_n", iss.size(), 2);
      if (ido.size() == 1 && iss.size() == 2) begin
         check("drop_done_cyc", ido[0], LAT + 2);
         check("drop_reissue", iss[1], 13);
      end

      // Random traffic against a transaction-level reference
      do_reset();
      busy = 0; g = 0; m_side = 0; m_wr = 0; m_last = 0;
      m_addr = 0; m_wdata = 0; m_rd = 0; m_idata = 0; m_ddata = 0; m_icnt = 0; m_dcnt = 0;
      i_act = 0; d_act = 0; i_drop = 0; d_drop = 0;
      r_iaddr = 0; r_daddr = 0; r_dwdata = 0; r_dwr = 0;
      for (int t = 0; t < 3000; t++) begin
         ph = busy ? t - g : -1;
         if (!i_act && $urandom_range(2) == 0) begin
            i_act = 1; i_drop = 0; r_iaddr = 16'($urandom);
         end
         if (!d_act && $urandom_range(2) == 0) begin
            d_act = 1; d_drop = 0; r_daddr = 16'($urandom);
            r_dwdata = 16'($urandom); r_dwr = 1'($urandom);
         end
         if (busy && ph >= 2 && !m_side && $urandom_range(15) == 0) i_drop = 1;
         if (busy && ph >= 2 && m_side && $urandom_range(15) == 0) d_drop = 1;
         i_req = i_act && !i_drop; i_addr = r_iaddr;
         d_req = d_act && !d_drop; d_addr = r_daddr; d_wdata = r_dwdata; d_wr = r_dwr;
         mem_rdata = (busy && ph == LAT + 1) ? m_rd : 16'($urandom);
         @(negedge clk);
         check("rnd_en", mem_en, busy && ph == 1);
         check("rnd_wr", mem_wr, busy && ph == 1 && m_wr);
         check("rnd_addr", mem_addr, (busy && ph == 1) ? m_addr : 16'h0);
         check("rnd_wdata", mem_wdata, (busy && ph == 1) ? m_wdata : 16'h0);
         check("rnd_idone", i_done, busy && ph == LAT + 2 && !m_side);
         check("rnd_ddone", d_done, busy && ph == LAT + 2 && m_side);
         check("rnd_idata", i_data, m_idata);
         check("rnd_ddata", d_data, m_ddata);
         check("rnd_icnt", i_grant_cnt, m_icnt);
         check("rnd_dcnt", d_grant_cnt, m_dcnt);
         if (busy) begin
            if (ph == LAT + 1 && !m_wr) begin
               if (m_side) m_ddata = m_rd;
               else        m_idata = m_rd;
            end
            if (ph == LAT + 2) begin
               if (m_side) begin
                  if (m_dcnt < 65535) m_dcnt++;
                  d_act = 0;
               end else begin
                  if (m_icnt < 65535) m_icnt++;
                  i_act = 0;
               end
               busy = 0;
            end
         end else if (i_req || d_req) begin
            if (i_req && d_req) m_side = !m_last;
            else                m_side = d_req;
            m_last = m_side; busy = 1; g = t;
            m_wr = m_side ? d_wr : 1'b0;
            m_addr = m_side ? d_addr : i_addr;
            m_wdata = m_side ? d_wdata : 16'h0;
            m_rd = 16'($urandom);
         end
         tick();
      end

      // LAT=1 instance: done spacing and saturation from a preset count
      s_rst = 1'b1;
      tick();
      tick();
      s_rst = 1'b0;
      @(negedge clk);
      force dut_sat.i_cnt_q = 16'hFFFD;
      #1;
      release dut_sat.i_cnt_q;
      tick();
      s_done.delete();
      s_exp_cnt = 16'hFFFD;
      s_i_req = 1'b1; s_i_addr = 16'h0033;
      for (int c = 0; c < 18; c++) begin
         s_rd[c] = 16'($urandom);
         s_mem_rdata = s_rd[c];
         @(negedge clk);
         check("sat_cnt", s_i_cnt, s_exp_cnt);
         if (s_i_done) begin
            s_done.push_back(c);
            check("sat_data", s_i_data, s_rd[c-1]);
            if (s_exp_cnt < 16'hFFFF) s_exp_cnt++;
         end
         tick();
      end
      check("sat_done_n", s_done.size(), 4);
      if (s_done.size() == 4) begin
         check("sat_first", s_done[0], 3);
         for (int k = 1; k < 4; k++) check("sat_spacing", s_done[k] - s_done[k-1], 4);
      end
      check("sat_final", s_i_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 4, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-side read request (I-cache miss fill); held high until i_done.
REQ-005 i_addr  input  16  instruction-side word address.
REQ-006 i_done  output  1  one-cycle pulse; instruction transaction complete.
REQ-007 i_data  output  16  instruction read data, valid while i_done=1.
REQ-008 d_req  input  1  data-side request (D-cache miss fill or writeback); held high until d_done.
REQ-009 d_wr  input  1  data-side direction: 1 write, 0 read.
REQ-010 d_addr  input  16  data-side address.
REQ-011 d_wdata  input  16  data-side write data.
REQ-012 d_done  output  1  one-cycle pulse; data transaction complete.
REQ-013 d_data  output  16  data read data, valid while d_done=1 on reads.
REQ-014 mem_en  output  1  one-cycle memory access strobe.
REQ-015 mem_wr  output  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  output  16  memory address.
REQ-017 mem_wdata  output  16  memory write data.
REQ-018 mem_rdata  input  16  memory read data, valid exactly LAT cycles after the mem_en cycle.
REQ-019 i_grant_cnt  output  16  count of completed instruction transactions, saturating at 0xFFFF.
REQ-020 d_grant_cnt  output  16  count of completed data transactions, saturating at 0xFFFF.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight at a time.
REQ-022 IDLE: request(s) sampled at rising edge; a grant latches the winner, address, wr and wdata into holding registers; next state ISSUE; no request -> stay IDLE.
REQ-023 Arbitration: only one requester -> it wins; both -> round-robin, winner is the side not granted last; last-granted resets to I, so D wins the first tie.
REQ-024 ISSUE: exactly one cycle; mem_en=1, mem_addr/mem_wr/mem_wdata driven from holding registers; next state WAIT with latency counter loaded.
REQ-025 WAIT: LAT cycles counted from the ISSUE cycle; in the cycle mem_rdata is valid (ISSUE+LAT), data is captured; next state DONE.
REQ-026 Writes follow the same timing as reads; mem_rdata is ignored, and d_data holds its previous value.
REQ-027 DONE: exactly one cycle; granted side's done=1 with captured data; grant counter for that side increments unless already 0xFFFF; next state IDLE.
REQ-028 Latency: request in IDLE cycle t -> ISSUE t+1 -> done in cycle t+2+LAT; back-to-back requests from the same side are separated by one IDLE cycle.
REQ-029 mem_en, mem_wr, i_done and d_done are 0 in every state except as specified; mem_addr/mem_wdata are 0 outside ISSUE.
REQ-030 Request inputs are ignored outside IDLE; a request deasserted mid-transaction does not abort it, and done still pulses.
REQ-031 i_done and d_done are never high in the same cycle.

Reset
REQ-032 rst=1 at a rising edge: state IDLE, last-granted=I, holding registers, latency counter, i_data, d_data, both grant counters and all outputs 0, regardless of the current state.
REQ-033 Reset mid-transaction aborts the transaction: no done pulse and no counter increment for it; the first arbitration occurs in the cycle after rst deasserts.

Verification
REQ-034 LAT=4; i_req, i_addr=0x0040 in cycle 0; memory returns 0xBEEF in cycle 5 -> mem_en=1 and mem_addr=0x0040 in cycle 1 only, i_done=1 and i_data=0xBEEF in cycle 6, i_grant_cnt=1.
REQ-035 After reset, i_req and d_req rise together and stay high -> D served first (d_done in cycle 6), then I (ISSUE cycle 8, i_done cycle 13); the next tie is won by D.
REQ-036 d_req, d_wr=1, d_addr=0x1000, d_wdata=0x1234 -> in cycle 1 mem_en=1, mem_wr=1, mem_addr=0x1000, mem_wdata=0x1234; d_done in cycle 6; d_data unchanged.
REQ-037 i_req in cycle 0, rst=1 in cycle 3 -> all outputs 0 from cycle 4; no i_done; i_grant_cnt=0.
REQ-038 LAT=1; i_req held high for 65537 transactions -> i_grant_cnt reaches 0xFFFF and stays there; done spacing is 4 cycles.
REQ-039 i_req dropped in cycle 2 of an I transaction -> i_done still pulses in cycle 2+LAT; FSM returns to IDLE.
